// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // Owner to one-hot port select: bit 0 is IFU, bit 1 is LSU.
  function automatic logic [1:0] own_onehot(input logic owner);
    logic [1:0] oh;
    case (owner)
      OWN_IFU: oh = 2'b01;
      OWN_LSU: oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction
endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin selector; grant bit 0 is IFU, bit 1 is LSU.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // Pick the sole requester, or on a tie the one not granted last.
  always_comb begin
    grant = 2'b00;
    if (!enable) begin
      grant = 2'b00;
    end else if (ifu_valid && lsu_valid) begin
      grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
    end else if (ifu_valid) begin
      grant = 2'b01;
    end else if (lsu_valid) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU onto one memory port with a single outstanding
// transaction and a response timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              arb_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  arb_state_t        state_r;
  logic              owner_r;
  logic              last_grant_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [MASK_W-1:0] wmask_r;
  logic              wen_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [1:0]        grant_s;
  logic [1:0]        owner_oh_s;
  logic              in_idle_s;
  logic              in_req_s;
  logic              in_wait_s;
  logic              timeout_s;
  logic              resp_valid_s;
  logic [DATA_W-1:0] resp_data_s;

  // Gating on the reset pin keeps req_ready low while reset is held.
  assign in_idle_s  = (state_r == ST_IDLE) && sys_rst;
  assign in_req_s   = (state_r == ST_REQ);
  assign in_wait_s  = (state_r == ST_WAIT);
  assign owner_oh_s = own_onehot(owner_r);
  // cnt_r counts completed WAIT cycles, so the abort lands on WAIT cycle TIMEOUT_CYCLES.
  assign timeout_s  = in_wait_s && !mem_resp_valid && (cnt_r >= CNT_LAST);

  mem_arb_rr2 u_rr2 (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant_r),
    .enable     (in_idle_s),
    .grant      (grant_s)
  );

  assign ifu_req_ready = grant_s[0];
  assign lsu_req_ready = grant_s[1];

  // Response source: memory data wins over a coincident timeout.
  always_comb begin
    resp_valid_s = 1'b0;
    resp_data_s  = {DATA_W{1'b0}};
    if (in_wait_s && mem_resp_valid) begin
      resp_valid_s = 1'b1;
      resp_data_s  = mem_resp_data;
    end else if (timeout_s) begin
      resp_valid_s = 1'b1;
      resp_data_s  = {DATA_W{1'b0}};
    end else begin
      resp_valid_s = 1'b0;
      resp_data_s  = {DATA_W{1'b0}};
    end
  end

  assign ifu_resp_valid = resp_valid_s & owner_oh_s[0];
  assign lsu_resp_valid = resp_valid_s & owner_oh_s[1];
  assign ifu_resp_data  = owner_oh_s[0] ? resp_data_s : {DATA_W{1'b0}};
  assign lsu_resp_data  = owner_oh_s[1] ? resp_data_s : {DATA_W{1'b0}};
  assign arb_timeout    = timeout_s;

  assign mem_req_valid = in_req_s;
  assign mem_wen       = in_req_s ? wen_r : 1'b0;
  assign mem_addr      = in_req_s ? addr_r : {ADDR_W{1'b0}};
  assign mem_wdata     = in_req_s ? wdata_r : {DATA_W{1'b0}};
  assign mem_wmask     = in_req_s ? wmask_r : {MASK_W{1'b0}};

  // Transaction FSM: accept, issue, wait for response or timeout.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_IFU;
      last_grant_r <= OWN_LSU;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      wmask_r      <= {MASK_W{1'b0}};
      wen_r        <= 1'b0;
      cnt_r        <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s[1]) begin
            state_r      <= ST_REQ;
            owner_r      <= OWN_LSU;
            last_grant_r <= OWN_LSU;
            addr_r       <= lsu_addr;
            wdata_r      <= lsu_wdata;
            wmask_r      <= lsu_wmask;
            wen_r        <= lsu_wen;
          end else if (grant_s[0]) begin
            state_r      <= ST_REQ;
            owner_r      <= OWN_IFU;
            last_grant_r <= OWN_IFU;
            addr_r       <= ifu_addr;
            wdata_r      <= {DATA_W{1'b0}};
            wmask_r      <= {MASK_W{1'b0}};
            wen_r        <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state_r <= ST_WAIT;
            cnt_r   <= CNT_ZERO;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid || timeout_s) begin
            state_r <= ST_IDLE;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
